// File: rtl/ls138_pkg.sv
// Shared types and constants for the clocked 74LS138 decoder.
package ls138_pkg;

    typedef logic [2:0] ls138_sel_t;
    typedef logic [7:0] ls138_out_t;

    localparam ls138_out_t LS138_ALL_HIGH = 8'hFF;

endpackage : ls138_pkg

// File: rtl/ls138_dec_core.sv
// Combinational 3-to-8 decode producing an active-low one-cold vector.
module ls138_dec_core
    import ls138_pkg::*;
(
    input  ls138_sel_t sel,
    input  logic       en,
    output ls138_out_t dec_n_c
);

    always_comb begin
        dec_n_c = LS138_ALL_HIGH;
        if (en) begin
            dec_n_c[sel] = 1'b0;
        end
    end

endmodule : ls138_dec_core

// File: rtl/ls138_decoder.sv
// Clocked SN74LS138-equivalent decoder with registered active-low outputs.
// Optional registered _VALID port enabled by macro LS138_DECODE_VALID_EN.
module ls138_decoder
    import ls138_pkg::*;
(
    input  logic _CLK,
    input  logic _RST_N,
    input  logic _A,
    input  logic _B,
    input  logic _C,
    input  logic _G1,
    input  logic _G2A,
    input  logic _G2B,
`ifdef LS138_DECODE_VALID_EN
    output logic _VALID,
`endif
    output logic _Y0,
    output logic _Y1,
    output logic _Y2,
    output logic _Y3,
    output logic _Y4,
    output logic _Y5,
    output logic _Y6,
    output logic _Y7
);

    logic       en;
    ls138_sel_t sel;
    ls138_out_t dec_n_c;
    ls138_out_t y_q;

    assign en  = _G1 & ~_G2A & ~_G2B;
    assign sel = {_C, _B, _A};

    ls138_dec_core u_core (
        .sel     (sel),
        .en      (en),
        .dec_n_c (dec_n_c)
    );

    // Reset wins over enable so chip selects are all inactive at the reset edge.
    always_ff @(posedge _CLK) begin
        if (!_RST_N) begin
            y_q <= LS138_ALL_HIGH;
        end else begin
            y_q <= dec_n_c;
        end
    end

`ifdef LS138_DECODE_VALID_EN
    logic valid_q;

    always_ff @(posedge _CLK) begin
        if (!_RST_N) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= en;
        end
    end

    assign _VALID = valid_q;
`endif

    assign _Y0 = y_q[0];
    assign _Y1 = y_q[1];
    assign _Y2 = y_q[2];
    assign _Y3 = y_q[3];
    assign _Y4 = y_q[4];
    assign _Y5 = y_q[5];
    assign _Y6 = y_q[6];
    assign _Y7 = y_q[7];

endmodule : ls138_decoder

// File: tb/tb_ls138_decoder.sv
// Table-driven, scoreboarded bench for ls138_decoder.
module tb_ls138_decoder;

    logic clk = 1'b0;
    logic rst_n, a, b, c, g1, g2a, g2b;
    logic y0, y1, y2, y3, y4, y5, y6, y7;
    logic valid;
    logic [7:0] y;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst_n;
        logic [2:0] sel;
        logic       g1;
        logic       g2a;
        logic       g2b;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic       valid;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    assign y = {y7, y6, y5, y4, y3, y2, y1, y0};

    ls138_decoder dut (
        ._CLK   (clk),
        ._RST_N (rst_n),
        ._A     (a),
        ._B     (b),
        ._C     (c),
        ._G1    (g1),
        ._G2A   (g2a),
        ._G2B   (g2b),
`ifdef LS138_DECODE_VALID_EN
        ._VALID (valid),
`endif
        ._Y0    (y0),
        ._Y1    (y1),
        ._Y2    (y2),
        ._Y3    (y3),
        ._Y4    (y4),
        ._Y5    (y5),
        ._Y6    (y6),
        ._Y7    (y7)
    );

`ifndef LS138_DECODE_VALID_EN
    assign valid = 1'b0;
`endif

    function automatic int count_low(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) if (!v[i]) n++;
        return n;
    endfunction

    // Drive one sample, push its expectation, then compare after the edge.
    task automatic apply(input string name, input logic r, input logic [2:0] s,
                         input logic e1, input logic e2a, input logic e2b,
                         input logic [7:0] exp);
        sb_t got_exp;
        sb_t item;
        rst_n = r; {c, b, a} = s; g1 = e1; g2a = e2a; g2b = e2b;
        item.y = exp;
        item.valid = (exp != 8'hFF);
        sb.push_back(item);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        got_exp = sb.pop_front();
        if (y !== got_exp.y) begin
            errors++;
            $display("FAIL %s: y=%b expected %b", name, y, got_exp.y);
        end
        checks++;
        if (count_low(y) > 1 || (!(e1 && !e2a && !e2b) && count_low(y) != 0)) begin
            errors++;
            $display("FAIL %s onehot: y=%b has %0d low", name, y, count_low(y));
        end
`ifdef LS138_DECODE_VALID_EN
        checks++;
        if (valid !== got_exp.valid) begin
            errors++;
            $display("FAIL %s valid: got %b expected %b", name, valid, got_exp.valid);
        end
`endif
    endtask

    initial begin : main
        // Reset with enable on and sel=3: outputs stay inactive.
        vecs.push_back('{1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'hFF});
        vecs.push_back('{1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'hFF});
        // Select sweep with enable satisfied.
        vecs.push_back('{1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'b1111_1110});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'b1111_1101});
        vecs.push_back('{1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'b1111_1011});
        vecs.push_back('{1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'b1111_0111});
        vecs.push_back('{1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'b1110_1111});
        vecs.push_back('{1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 8'b1101_1111});
        vecs.push_back('{1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 8'b1011_1111});
        vecs.push_back('{1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 8'b0111_1111});
        // Enable combinations at sel=0; only {1,0,0} decodes.
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'hFF});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'hFF});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 8'hFF});
        vecs.push_back('{1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 8'hFF});
        vecs.push_back('{1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'hFF});
        vecs.push_back('{1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'b1111_1110});
        // Select changes while disabled stay invisible.
        vecs.push_back('{1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 8'hFF});
        vecs.push_back('{1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'hFF});
        // Select and enable change together.
        vecs.push_back('{1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'b1110_1111});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 8'hFF});

        rst_n = 1'b0; {c, b, a} = 3'd3; g1 = 1'b1; g2a = 1'b0; g2b = 1'b0;
        foreach (vecs[i])
            apply($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].sel, vecs[i].g1,
                  vecs[i].g2a, vecs[i].g2b, vecs[i].exp);

        // Reset mid-operation while decoding sel=6.
        apply("rst_pre",  1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 8'b1011_1111);
        apply("rst_mid",  1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 8'hFF);
        apply("rst_post", 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 8'b1011_1111);

        // Select change between edges: no effect until the next rising edge.
        apply("hold_pre", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'b1111_1011);
        {c, b, a} = 3'd7;
        #3;
        checks++;
        if (y !== 8'b1111_1011) begin
            errors++;
            $display("FAIL hold_mid: y=%b expected %b", y, 8'b1111_1011);
        end
        apply("hold_post", 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 8'b0111_1111);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: timeout at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule : tb_ls138_decoder
